// File: rtl/hpi_sequencer.sv
// hpi_sequencer: two-port arbiter and bus-cycle sequencer for the CY7C67200 host-port interface
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   sw_rst                one-cycle pulse requesting a chip reset (honoured only in IDLE)
//   req/wr/addr/wdata 0,1 single-word requests; port 0 = CPU bridge, port 1 = keyboard poller
//   ack 0,1 / rdata 0,1   one-cycle completion pulse and read data (held until next ack)
//   busy                  high whenever the sequencer is not IDLE
//   hpi_*                 registered HPI bus signals; hpi_data_in is the chip's read data
//
// Build option: define HPI_FIXED_PRIO_EN for fixed priority (port 0 wins);
// otherwise simultaneous requests are served round-robin.
module hpi_sequencer #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 1,
  parameter int RESET_CYC    = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sw_rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_rst_n,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in
);
  typedef enum logic [2:0] {RST, IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        gnt, gnt_d, wr_l, wr_d, sel, done, start, act, ack_n;
  logic [1:0]  addr_l, addr_d;
  logic [15:0] wdata_l, wdata_d, rd_cap, rd_src;
`ifndef HPI_FIXED_PRIO_EN
  logic        last_grant;
`endif
  always_comb begin
    done = cnt == 8'd1;
`ifdef HPI_FIXED_PRIO_EN
    sel = !req0;
`else
    sel = (req0 && req1) ? !last_grant : req1;
`endif
    state_n = state;
    cnt_n = cnt - 8'd1;
    case (state)
      RST: if (done) state_n = IDLE;
      IDLE: begin
        cnt_n = cnt;
        if (sw_rst) begin
          state_n = RST;
          cnt_n = 8'(RESET_CYC);
        end else if (req0 || req1) begin
          state_n = SETUP;
          cnt_n = 8'(SETUP_CYC);
        end
      end
      SETUP: if (done) begin
        state_n = STROBE;
        cnt_n = 8'(STROBE_CYC);
      end
      STROBE: if (done) begin
        state_n = HOLD;
        cnt_n = 8'(HOLD_CYC);
      end
      HOLD: if (done) begin
        state_n = RECOVER;
        cnt_n = 8'(RECOVERY_CYC);
      end
      RECOVER: if (done) state_n = IDLE;
      default: state_n = RST;
    endcase
    // Outputs are registered from the next state, so the request context must
    // also be the next-cycle view (fresh grant on the IDLE->SETUP edge).
    start = state == IDLE && state_n == SETUP;
    gnt_d = start ? sel : gnt;
    wr_d = start ? (sel ? wr1 : wr0) : wr_l;
    addr_d = start ? (sel ? addr1 : addr0) : addr_l;
    wdata_d = start ? (sel ? wdata1 : wdata0) : wdata_l;
    act = state_n == SETUP || state_n == STROBE || state_n == HOLD;
    ack_n = state_n == HOLD && cnt_n == 8'd1;
    // With a one-cycle HOLD the ack edge is the same edge that samples the bus.
    rd_src = state == STROBE ? hpi_data_in : rd_cap;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RST;
      cnt <= 8'(RESET_CYC);
      gnt <= 1'b0;
      wr_l <= 1'b0;
      addr_l <= 2'd0;
      wdata_l <= 16'd0;
      rd_cap <= 16'd0;
`ifndef HPI_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      hpi_rst_n <= 1'b0;
      busy <= 1'b1;
      hpi_cs_n <= 1'b1;
      hpi_r_n <= 1'b1;
      hpi_w_n <= 1'b1;
      hpi_addr <= 2'd0;
      hpi_data_out <= 16'd0;
      hpi_data_oe <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= 16'd0;
      rdata1 <= 16'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gnt <= gnt_d;
      wr_l <= wr_d;
      addr_l <= addr_d;
      wdata_l <= wdata_d;
`ifndef HPI_FIXED_PRIO_EN
      if (start) last_grant <= sel;
`endif
      if (state == STROBE && done) rd_cap <= hpi_data_in;
      hpi_rst_n <= state_n != RST;
      busy <= state_n != IDLE;
      hpi_cs_n <= !act;
      hpi_r_n <= !(state_n == STROBE && !wr_d);
      hpi_w_n <= !(state_n == STROBE && wr_d);
      hpi_addr <= addr_d;
      hpi_data_out <= wdata_d;
      hpi_data_oe <= act && wr_d;
      ack0 <= ack_n && !gnt_d;
      ack1 <= ack_n && gnt_d;
      if (ack_n && !wr_d && !gnt_d) rdata0 <= rd_src;
      if (ack_n && !wr_d && gnt_d) rdata1 <= rd_src;
    end
  end
endmodule
